// File: rtl/lzc_norm_pkg.sv
// Shared types and constants for the iterative post-add normalizer.
package lzc_norm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  // The mantissa is examined one nibble per SCAN step.
  localparam int NIBBLE_W = 4;

  // Two guard bits let the working exponent go negative without wrapping.
  localparam int EXP_GUARD_W = 2;

  function automatic int work_exp_w(input int exp_w);
    return exp_w + EXP_GUARD_W;
  endfunction

endpackage

// File: rtl/lzc_normalizer_seq_lzc4.sv
// 4-bit leading-zero counter: count of zeros above the first 1 (0..3);
// an all-zero nibble is flagged on is_zero instead of counted.
module leading_zero_counter_4_bit
  import lzc_norm_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble,
  output logic [1:0]          count,
  output logic                is_zero
);

  // Priority encode from the MSB down.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    count   = 2'd0;
    is_zero = 1'b0;
    casez (nibble)
      4'b1???: count = 2'd0;
      4'b01??: count = 2'd1;
      4'b001?: count = 2'd2;
      4'b0001: count = 2'd3;
      default: is_zero = 1'b1;
    endcase
  end

endmodule

// File: rtl/lzc_normalizer_seq.sv
// Iterative post-add normalizer: strips leading zeros one nibble per cycle.
// Optional macro LZC_NORM_BYPASS_EN: inputs whose MSB is already set skip
// SCAN and complete in one cycle (same results, shorter latency).
// MANT_W must be a multiple of 4 and at least 8.
module lzc_normalizer_seq
  import lzc_norm_pkg::*;
#(
  parameter int MANT_W  = 24,
  parameter int EXP_W   = 8,
  parameter int SHIFT_W = $clog2(MANT_W + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MANT_W-1:0]  in_mant,
  input  logic [EXP_W-1:0]   in_exp,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [MANT_W-1:0]  out_mant,
  output logic [EXP_W-1:0]   out_exp,
  output logic [SHIFT_W-1:0] out_shift,
  output logic               out_zero,
  output logic               out_underflow
);

  localparam int WEXP_W = work_exp_w(EXP_W);

  state_e state_q, state_d;

  // Working copy, modified every SCAN step.
  logic [MANT_W-1:0]        mant_q, mant_d;
  logic signed [WEXP_W-1:0] exp_q, exp_d;
  logic [SHIFT_W-1:0]       shift_q, shift_d;

  // Result registers, only updated on entry to DONE so they stay put while invalid.
  logic [MANT_W-1:0]  out_mant_q, out_mant_d;
  logic [EXP_W-1:0]   out_exp_q, out_exp_d;
  logic [SHIFT_W-1:0] out_shift_q, out_shift_d;
  logic               out_zero_q, out_zero_d;
  logic               out_underflow_q, out_underflow_d;

  logic [1:0] lzc_count;
  logic       lzc_is_zero;

  leading_zero_counter_4_bit u_lzc4 (
    .nibble  (mant_q[MANT_W-1 -: NIBBLE_W]),
    .count   (lzc_count),
    .is_zero (lzc_is_zero)
  );

  // Final-step values when the top nibble holds the leading one.
  logic [MANT_W-1:0]        mant_fin;
  logic signed [WEXP_W-1:0] exp_fin;
  logic [SHIFT_W-1:0]       shift_fin;

  assign mant_fin  = mant_q << lzc_count;
  assign exp_fin   = exp_q - WEXP_W'(lzc_count);
  assign shift_fin = shift_q + SHIFT_W'(lzc_count);

  assign in_ready      = (state_q == IDLE);
  assign out_valid     = (state_q == DONE);
  assign out_mant      = out_mant_q;
  assign out_exp       = out_exp_q;
  assign out_shift     = out_shift_q;
  assign out_zero      = out_zero_q;
  assign out_underflow = out_underflow_q;

  // Next-state and datapath updates for IDLE -> SCAN* -> DONE.
  always_comb begin
    state_d         = state_q;
    mant_d          = mant_q;
    exp_d           = exp_q;
    shift_d         = shift_q;
    out_mant_d      = out_mant_q;
    out_exp_d       = out_exp_q;
    out_shift_d     = out_shift_q;
    out_zero_d      = out_zero_q;
    out_underflow_d = out_underflow_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_mant == '0) begin
            // Zero exponent counts as underflow, like any other result <= 0.
            out_mant_d      = '0;
            out_exp_d       = '0;
            out_shift_d     = '0;
            out_zero_d      = 1'b1;
            out_underflow_d = 1'b1;
            state_d         = DONE;
          end
`ifdef LZC_NORM_BYPASS_EN
          else if (in_mant[MANT_W-1]) begin
            out_mant_d      = in_mant;
            out_exp_d       = in_exp;
            out_shift_d     = '0;
            out_zero_d      = 1'b0;
            out_underflow_d = (in_exp == '0);
            state_d         = DONE;
          end
`endif
          else begin
            mant_d  = in_mant;
            exp_d   = WEXP_W'(in_exp);
            shift_d = '0;
            state_d = SCAN;
          end
        end
      end

      SCAN: begin
        if (lzc_is_zero) begin
          mant_d  = mant_q << NIBBLE_W;
          exp_d   = exp_q - WEXP_W'(NIBBLE_W);
          shift_d = shift_q + SHIFT_W'(NIBBLE_W);
        end else begin
          mant_d          = mant_fin;
          exp_d           = exp_fin;
          shift_d         = shift_fin;
          out_mant_d      = mant_fin;
          out_shift_d     = shift_fin;
          out_zero_d      = 1'b0;
          out_underflow_d = (exp_fin <= 0);
          out_exp_d       = (exp_fin <= 0) ? '0 : exp_fin[EXP_W-1:0];
          state_d         = DONE;
        end
      end

      DONE: begin
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and data registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      // NOTE: working registers are cleared too, so an aborted operation leaves no residue.
      state_q         <= IDLE;
      mant_q          <= '0;
      exp_q           <= '0;
      shift_q         <= '0;
      out_mant_q      <= '0;
      out_exp_q       <= '0;
      out_shift_q     <= '0;
      out_zero_q      <= 1'b0;
      out_underflow_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      mant_q          <= mant_d;
      exp_q           <= exp_d;
      shift_q         <= shift_d;
      out_mant_q      <= out_mant_d;
      out_exp_q       <= out_exp_d;
      out_shift_q     <= out_shift_d;
      out_zero_q      <= out_zero_d;
      out_underflow_q <= out_underflow_d;
    end
  end

endmodule
